alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Upstream issue stage for the 8-bit ALU. Accepts register-addressed commands over valid/ready,
//  reads operands from a small local register file, drives alu_a/alu_b/alu_s, waits the ALU
//  latency, then captures the result. It writes the result back to the register file and
//  returns it on a valid/ready response port. One command in flight; no overlap.
// PARAMETERS
//  DATA_W   8  operand/result width
//  OP_W     4  ALU select width (matches ALU s port)
//  NREGS    4  register file depth; RA_W = $clog2(NREGS)
//  ALU_LAT  1  cycles (>=1) from alu_a/b/s stable to alu_result valid
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       synchronous, active-high
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       command accepted when cmd_valid & cmd_ready at rising edge
//  cmd_op      in   OP_W    ALU select, forwarded to alu_s
//  cmd_rd      in   RA_W    destination register
//  cmd_ra      in   RA_W    source A register
//  cmd_rb      in   RA_W    source B register (unused if cmd_imm_en)
//  cmd_imm_en  in   1       1: B operand = cmd_imm
//  cmd_imm     in   DATA_W  immediate B operand
//  wr_en       in   1       host register preload strobe
//  wr_addr     in   RA_W    preload address
//  wr_data     in   DATA_W  preload data
//  alu_a       out  DATA_W  to ALU A
//  alu_b       out  DATA_W  to ALU B
//  alu_s       out  OP_W    to ALU s
//  alu_result  in   DATA_W  from ALU alu_out
//  rsp_valid   out  1       result available
//  rsp_ready   in   1       consumer accepts result
//  rsp_data    out  DATA_W  captured result
//  rsp_rd      out  RA_W    destination of rsp_data
//  busy        out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset (sync): state=IDLE; all registers and rf[*]=0; cmd_ready=0 during reset; alu_a/b/s=0;
//    rsp_valid=0, rsp_data=0, rsp_rd=0; busy=0. First cycle after reset: cmd_ready=1.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: cmd_ready = ~wr_en. On accept at edge T: latch op/rd; latch A=rf[ra];
//    latch B = cmd_imm_en ? cmd_imm : rf[rb]. Operands are read at accept, so ra==rd is safe.
//    Drive alu_a/b/s from registers, valid from T. Go to EXEC; load lat_cnt=ALU_LAT.
//  - EXEC: alu_a/b/s held constant. lat_cnt decrements each edge. At edge T+1+ALU_LAT: capture
//    alu_result into rsp_data, write rf[rd], set rsp_rd, go to RESP.
//  - RESP: rsp_valid=1. rsp_data/rsp_rd stable until handshake. On rsp_valid & rsp_ready: go to
//    IDLE, rsp_valid=0 next cycle. Earliest next accept is the edge after the handshake edge.
//  - alu_a/b/s keep their last values in IDLE; no toggling without a new command.
//  - wr_en is honoured only in IDLE and has priority over cmd (cmd_ready forced 0).
//    wr_en in EXEC/RESP is silently ignored.
//  - Arithmetic lives entirely in the ALU. Results are DATA_W bits and wrap; no carry or flags here.
//  - Reset in EXEC/RESP aborts: no response is emitted; state and rf are cleared as above.
// STRUCTURE
//  - Shared package alu_pkg: ALU opcode localparams (ALU_ADD=4'b0000, ...) and FSM state encoding
//    (IDLE/EXEC/RESP, 2 bits).
//  - Sub-module alu_regfile: NREGS x DATA_W, 2 async read ports, 1 sync write port, sync reset.
//    The write port muxes host preload (IDLE) and writeback (EXEC capture).
//  - Top level: FSM, lat_cnt, operand and response registers.
// TESTING (bench uses a behavioural ALU model with a parameterised ALU_LAT; add for s=0000)
//  1 reset held 3 cycles -> all outputs 0 during reset; cmd_ready=1 the first cycle after release.
//  2 preload r0=8'h7B, r1=8'h5B; cmd op=0000 ra=0 rb=1 rd=2 at T -> alu_a=7B alu_b=5B alu_s=0
//    from T; rsp_valid=1 rsp_data=8'hD6 rsp_rd=2 after edge T+2 (ALU_LAT=1).
//  3 cmd ra=2 imm_en=1 imm=8'h2A op=0000 rd=3 -> rsp_data=8'h00 (wrap); then cmd ra=3 rb=3 rd=3
//    -> 8'h00.
//  4 hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, busy=1.
//    On handshake: cmd_ready=1 next cycle.
//  5 wr_en and cmd_valid together in IDLE -> write lands, cmd_ready=0 that cycle, cmd accepted next
//    cycle. wr_en during EXEC -> rf unchanged.
//  6 assert reset one cycle into EXEC -> rsp_valid never rises; rf all 0; rerun with ALU_LAT=3 ->
//    capture at T+4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU opcodes and the issue FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_regfile.sv
// Small operand register file: two asynchronous read ports, one synchronous write port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    localparam int RA_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr_a,
    input  logic [RA_W-1:0]   raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];

    always_comb begin
        rf_d = rf_q;
        if (we) begin
            rf_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    assign rdata_a = rf_q[raddr_a];
    assign rdata_b = rf_q[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the external ALU: one command in flight, operands from the local register file,
// result written back and returned on a valid/ready response port.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 4,
    parameter int NREGS   = 4,
    parameter int ALU_LAT = 1,
    localparam int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [RA_W-1:0]   cmd_rd,
    input  logic [RA_W-1:0]   cmd_ra,
    input  logic [RA_W-1:0]   cmd_rb,
    input  logic              cmd_imm_en,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              wr_en,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_s,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [RA_W-1:0]   rsp_rd,
    output logic              busy
);

    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  lat_cnt_q,  lat_cnt_d;
    logic [DATA_W-1:0] a_q,        a_d;
    logic [DATA_W-1:0] b_q,        b_d;
    logic [OP_W-1:0]   op_q,       op_d;
    logic [RA_W-1:0]   rd_q,       rd_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [RA_W-1:0]   rsp_rd_q,   rsp_rd_d;

    logic              accept;
    logic              capture;
    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;

    // Host preload owns the IDLE cycle it appears in, so commands stall behind it.
    assign cmd_ready = ~reset & (state_q == ST_IDLE) & ~wr_en;
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;
        rsp_rd_d   = rsp_rd_q;
        capture    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d       = rf_rdata_a;
                    b_d       = cmd_imm_en ? cmd_imm : rf_rdata_b;
                    op_d      = cmd_op;
                    rd_d      = cmd_rd;
                    lat_cnt_d = CNT_W'(ALU_LAT);
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (lat_cnt_q == '0) begin
                    capture    = 1'b1;
                    rsp_data_d = alu_result;
                    rsp_rd_d   = rd_q;
                    state_d    = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
            rsp_rd_q   <= rsp_rd_d;
        end
    end

    // Writeback and host preload never coincide: preload is IDLE-only, capture is EXEC-only.
    assign rf_we    = capture | ((state_q == ST_IDLE) & wr_en);
    assign rf_waddr = capture ? rd_q : wr_addr;
    assign rf_wdata = capture ? alu_result : wr_data;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (cmd_ra),
        .raddr_b (cmd_rb),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_s     = op_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with behavioural ALU models at latency 1 and latency 3.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DW = 8;
    localparam int OW = 4;
    localparam int NR = 4;
    localparam int RW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 instance
    logic          reset, cmd_valid, cmd_ready, cmd_imm_en, wr_en;
    logic [OW-1:0] cmd_op, alu_s;
    logic [RW-1:0] cmd_rd, cmd_ra, cmd_rb, wr_addr, rsp_rd;
    logic [DW-1:0] cmd_imm, wr_data, alu_a, alu_b, alu_result, rsp_data;
    logic          rsp_valid, rsp_ready, busy;

    // Latency-3 instance
    logic          reset3, cmd_valid3, cmd_ready3, cmd_imm_en3, wr_en3;
    logic [OW-1:0] cmd_op3, alu_s3;
    logic [RW-1:0] cmd_rd3, cmd_ra3, cmd_rb3, wr_addr3, rsp_rd3;
    logic [DW-1:0] cmd_imm3, wr_data3, alu_a3, alu_b3, alu_result3, rsp_data3;
    logic          rsp_valid3, rsp_ready3, busy3;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] rd;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] rf_m [NR];
    logic [DW-1:0] pipe3 [3];

    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] s, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (s)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return a;
        endcase
    endfunction

    always_ff @(posedge clk) alu_result <= alu_f(alu_s, alu_a, alu_b);

    always_ff @(posedge clk) begin
        pipe3[0] <= alu_f(alu_s3, alu_a3, alu_b3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign alu_result3 = pipe3[2];

    alu_issue_ctrl #(.DATA_W(DW), .OP_W(OW), .NREGS(NR), .ALU_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_rd(rsp_rd), .busy(busy)
    );

    alu_issue_ctrl #(.DATA_W(DW), .OP_W(OW), .NREGS(NR), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op3), .cmd_rd(cmd_rd3), .cmd_ra(cmd_ra3), .cmd_rb(cmd_rb3),
        .cmd_imm_en(cmd_imm_en3), .cmd_imm(cmd_imm3), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3),
        .alu_result(alu_result3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_rd(rsp_rd3), .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_s"}, alu_s, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_rd"}, rsp_rd, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic preload(input logic [RW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        rf_m[a] = d;
    endtask

    task automatic issue(input logic [OW-1:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] ra,
                         input logic [RW-1:0] rb, input logic ie, input logic [DW-1:0] imm);
        int n;
        logic [DW-1:0] b;
        exp_t e;
        cmd_op = op;
        cmd_rd = rd;
        cmd_ra = ra;
        cmd_rb = rb;
        cmd_imm_en = ie;
        cmd_imm = imm;
        cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("cmd_ready_accept", cmd_ready, 1);
        b = ie ? imm : rf_m[rb];
        e.data = alu_f(op, rf_m[ra], b);
        e.rd = rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("alu_a", alu_a, rf_m[ra]);
        check("alu_b", alu_b, b);
        check("alu_s", alu_s, op);
        check("busy_exec", busy, 1);
        rf_m[rd] = e.data;
    endtask

    task automatic wait_rsp(input int hold, input int exp_n);
        int n;
        exp_t e;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("rsp_latency", n, exp_n);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_rd", rsp_rd, e.rd);
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_rsp_valid", rsp_valid, 1);
                check("hold_rsp_data", rsp_data, e.data);
                check("hold_cmd_ready", cmd_ready, 0);
                check("hold_busy", busy, 1);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("cmd_ready_after_hs", cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
        cmd_imm_en = 1'b0; cmd_imm = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;
        reset3 = 1'b1; cmd_valid3 = 1'b0; cmd_op3 = '0; cmd_rd3 = '0; cmd_ra3 = '0; cmd_rb3 = '0;
        cmd_imm_en3 = 1'b0; cmd_imm3 = '0; wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0;
        rsp_ready3 = 1'b0;
        for (int i = 0; i < NR; i++) rf_m[i] = '0;

        // Reset held three cycles
        repeat (3) begin
            tick();
            check_idle_zero("rst");
            check("rst_cmd_ready", cmd_ready, 0);
        end
        reset = 1'b0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Basic add 7B + 5B
        preload(0, 8'h7B);
        preload(1, 8'h5B);
        issue(ALU_ADD, 2, 0, 1, 1'b0, 8'h00);
        wait_rsp(0, 2);
        check("r2_is_d6", rf_m[2], 8'hD6);

        // Wrap via immediate, then rd==ra==rb on a zero register
        issue(ALU_ADD, 3, 2, 0, 1'b1, 8'h2A);
        wait_rsp(0, 2);
        issue(ALU_ADD, 3, 3, 3, 1'b0, 8'h00);
        wait_rsp(0, 2);

        // Backpressure on the response port
        issue(ALU_SUB, 0, 2, 1, 1'b0, 8'h00);
        wait_rsp(5, 2);

        // Preload has priority over a concurrent command
        wr_en = 1'b1; wr_addr = 0; wr_data = 8'h11;
        cmd_op = ALU_ADD; cmd_rd = 2; cmd_ra = 0; cmd_rb = 1; cmd_imm_en = 1'b0; cmd_valid = 1'b1;
        #1;
        check("cmd_ready_wr_prio", cmd_ready, 0);
        tick();
        wr_en = 1'b0;
        rf_m[0] = 8'h11;
        issue(ALU_ADD, 2, 0, 1, 1'b0, 8'h00);
        wait_rsp(0, 2);

        // Preload during EXEC is dropped
        issue(ALU_XOR, 3, 1, 2, 1'b0, 8'h00);
        wr_en = 1'b1; wr_addr = 1; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        wait_rsp(0, 1);
        issue(ALU_OR, 0, 1, 0, 1'b1, 8'h00);
        wait_rsp(0, 2);

        // Reset one cycle into EXEC aborts the command and clears the register file
        preload(0, 8'h21); preload(1, 8'h32); preload(2, 8'h43); preload(3, 8'h54);
        issue(ALU_ADD, 1, 2, 3, 1'b0, 8'h00);
        reset = 1'b1;
        void'(sb.pop_back());
        for (int i = 0; i < NR; i++) rf_m[i] = '0;
        tick();
        check_idle_zero("abort");
        check("abort_cmd_ready", cmd_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_rsp", rsp_valid, 0);
        end
        issue(ALU_ADD, 0, 0, 1, 1'b0, 8'h00);
        wait_rsp(0, 2);
        issue(ALU_ADD, 1, 2, 3, 1'b0, 8'h00);
        wait_rsp(0, 2);

        // Latency-3 instance: capture at the fourth edge after accept
        reset3 = 1'b0;
        tick();
        wr_en3 = 1'b1; wr_addr3 = 0; wr_data3 = 8'h10;
        tick();
        wr_addr3 = 1; wr_data3 = 8'h20;
        tick();
        wr_en3 = 1'b0;
        cmd_op3 = ALU_ADD; cmd_rd3 = 2; cmd_ra3 = 0; cmd_rb3 = 1; cmd_imm_en3 = 1'b0;
        cmd_valid3 = 1'b1;
        #1;
        check("l3_cmd_ready", cmd_ready3, 1);
        @(posedge clk);
        #1;
        cmd_valid3 = 1'b0;
        check("l3_alu_a", alu_a3, 8'h10);
        check("l3_alu_b", alu_b3, 8'h20);
        n = 0;
        while (!rsp_valid3 && n < 20) begin
            tick();
            n++;
        end
        check("l3_latency", n, 4);
        check("l3_rsp_data", rsp_data3, 8'h30);
        check("l3_rsp_rd", rsp_rd3, 2);
        check("l3_busy", busy3, 1);
        rsp_ready3 = 1'b1;
        tick();
        rsp_ready3 = 1'b0;
        check("l3_rsp_valid_after_hs", rsp_valid3, 0);
        check("l3_cmd_ready_after_hs", cmd_ready3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
